// File: rtl/vip_color_space_convert.sv
// vip_color_space_convert
//  Pixel-stream colour-space converter with a fixed 3-clock latency.
//  MODE 0: RGB888 -> YCbCr444 (full-range BT.601)
//  MODE 1: YCbCr444 -> RGB888
//  MODE 2: YCbCr422 -> YCbCr444 (chroma pairing across adjacent pixels)
// Ports
//  clk                   pixel clock, rising edge
//  rst                   synchronous reset, active high
//  per_frame_vsync/href/clken   input timing
//  per_img_data[23:0]    input pixel (MODE0 {R,G,B}, MODE1 {Y,Cb,Cr}, MODE2 {-,C,Y})
//  post_frame_vsync/href/clken  timing delayed 3 clocks
//  post_img_data[23:0]   output pixel (MODE0/2 {Y,Cb,Cr}, MODE1 {R,G,B})
module vip_color_space_convert #(
    parameter int unsigned MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic [23:0] per_img_data,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic [23:0] post_img_data
);

    localparam int unsigned CW = 12;  // coefficient width
    localparam int unsigned PW = 20;  // product width
    localparam int unsigned SW = 21;  // sum width

    logic [2:0]  vs_q, hr_q, ce_q;
    logic [23:0] data_d, data_q;

    // Timing delay line and output data register
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q   <= '0;
            hr_q   <= '0;
            ce_q   <= '0;
            data_q <= '0;
        end else begin
            vs_q   <= {vs_q[1:0], per_frame_vsync};
            hr_q   <= {hr_q[1:0], per_frame_href};
            ce_q   <= {ce_q[1:0], per_frame_clken};
            data_q <= data_d;
        end
    end

    assign post_frame_vsync = vs_q[2];
    assign post_frame_href  = hr_q[2];
    assign post_frame_clken = ce_q[2];
    assign post_img_data    = data_q;

    if (MODE == 2) begin : g_422
        logic [7:0] y1_q, c1_q, y2_q, c2_q, cb_q, cr_q;
        logic       ph1_q, v1_q, ph2_q, v2_q, ph_q, ph_d;
        logic [7:0] cb, cr;
        logic       unused_hi;

        assign unused_hi = ^per_img_data[23:16];

        // Phase restarts on every line, toggles per qualified sample
        always_comb begin
            ph_d = ph_q;
            if (!per_frame_href) begin
                ph_d = 1'b0;
            end else if (per_frame_clken) begin
                ph_d = ~ph_q;
            end
        end

        // Two sample stages plus last-seen Cb/Cr holders
        always_ff @(posedge clk) begin
            if (rst) begin
                ph_q  <= 1'b0;
                y1_q  <= '0;
                c1_q  <= '0;
                ph1_q <= 1'b0;
                v1_q  <= 1'b0;
                y2_q  <= '0;
                c2_q  <= '0;
                ph2_q <= 1'b0;
                v2_q  <= 1'b0;
                cb_q  <= '0;
                cr_q  <= '0;
            end else begin
                ph_q  <= ph_d;
                y1_q  <= per_img_data[7:0];
                c1_q  <= per_img_data[15:8];
                ph1_q <= ph_q;
                v1_q  <= per_frame_href & per_frame_clken;
                y2_q  <= y1_q;
                c2_q  <= c1_q;
                ph2_q <= ph1_q;
                v2_q  <= v1_q;
                if (v2_q && !ph2_q) cb_q <= c2_q;
                if (v2_q && ph2_q)  cr_q <= c2_q;
            end
        end

        // Phase-0 pixel looks ahead one stage for its partner's Cr;
        // with no partner it falls back to the last Cr seen.
        always_comb begin
            cb = c2_q;
            cr = c2_q;
            if (!ph2_q) begin
                cr = (v1_q && ph1_q) ? c1_q : cr_q;
            end else begin
                cb = cb_q;
            end
            data_d = {y2_q, cb, cr};
        end
    end else begin : g_mat
        logic signed [PW-1:0] prod_d [3][3];
        logic signed [PW-1:0] prod_q [3][3];
        logic signed [SW-1:0] sum_d  [3];
        logic signed [SW-1:0] sum_q  [3];

        function automatic logic signed [CW-1:0] coef(input int unsigned r, input int unsigned c);
            logic signed [CW-1:0] k;
            k = '0;
            if (MODE == 1) begin
                case (r * 3 + c)
                    0: k = CW'(256);
                    2: k = CW'(359);
                    3: k = CW'(256);
                    4: k = CW'(-88);
                    5: k = CW'(-183);
                    6: k = CW'(256);
                    7: k = CW'(454);
                    default: k = '0;
                endcase
            end else begin
                case (r * 3 + c)
                    0: k = CW'(77);
                    1: k = CW'(150);
                    2: k = CW'(29);
                    3: k = CW'(-43);
                    4: k = CW'(-85);
                    5: k = CW'(128);
                    6: k = CW'(128);
                    7: k = CW'(-107);
                    8: k = CW'(-21);
                    default: k = '0;
                endcase
            end
            return k;
        endfunction

        function automatic logic signed [SW-1:0] offset(input int unsigned r);
            logic signed [SW-1:0] o;
            o = '0;
            if (MODE == 1) begin
                case (r)
                    0: o = SW'(-45952);
                    1: o = SW'(34688);
                    default: o = SW'(-58112);
                endcase
            end else begin
                o = (r == 0) ? SW'(0) : SW'(32768);
            end
            return o;
        endfunction

        // Stage 1: coefficient products on zero-extended 8-bit channels
        always_comb begin
            for (int unsigned r = 0; r < 3; r++) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    prod_d[r][c] = PW'(coef(r, c)) *
                                   PW'($signed({1'b0, per_img_data[23 - 8 * c -: 8]}));
                end
            end
        end

        // Stage 2: signed sums including offset
        always_comb begin
            for (int unsigned r = 0; r < 3; r++) begin
                sum_d[r] = SW'(prod_q[r][0]) + SW'(prod_q[r][1]) + SW'(prod_q[r][2]) + offset(r);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned r = 0; r < 3; r++) begin
                    sum_q[r] <= '0;
                    for (int unsigned c = 0; c < 3; c++) prod_q[r][c] <= '0;
                end
            end else begin
                for (int unsigned r = 0; r < 3; r++) begin
                    sum_q[r] <= sum_d[r];
                    for (int unsigned c = 0; c < 3; c++) prod_q[r][c] <= prod_d[r][c];
                end
            end
        end

        // Stage 3: arithmetic >>8 then clamp to 0..255
        always_comb begin
            logic signed [SW-1:0] sh;
            data_d = '0;
            for (int unsigned r = 0; r < 3; r++) begin
                sh = sum_q[r] >>> 8;
                if (sh[SW-1]) begin
                    data_d[23 - 8 * r -: 8] = 8'h00;
                end else if (|sh[SW-2:8]) begin
                    data_d[23 - 8 * r -: 8] = 8'hFF;
                end else begin
                    data_d[23 - 8 * r -: 8] = sh[7:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_vip_color_space_convert.sv
// Directed bench: three converters (one per MODE) on a shared input stream,
// plus a MODE1 converter chained after the MODE0 one for round-trip checks.
module tb_vip_color_space_convert;

    logic        clk = 1'b0;
    logic        rst;
    logic        vs, hr, ce;
    logic [23:0] din;

    logic        o0_vs, o0_hr, o0_ce, o1_vs, o1_hr, o1_ce, o2_vs, o2_hr, o2_ce;
    logic        r_vs, r_hr, r_ce;
    logic [23:0] o0_d, o1_d, o2_d, r_d;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vip_color_space_convert #(.MODE(0)) u0 (
        .clk(clk), .rst(rst), .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce),
        .per_img_data(din), .post_frame_vsync(o0_vs), .post_frame_href(o0_hr),
        .post_frame_clken(o0_ce), .post_img_data(o0_d));

    vip_color_space_convert #(.MODE(1)) u1 (
        .clk(clk), .rst(rst), .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce),
        .per_img_data(din), .post_frame_vsync(o1_vs), .post_frame_href(o1_hr),
        .post_frame_clken(o1_ce), .post_img_data(o1_d));

    vip_color_space_convert #(.MODE(2)) u2 (
        .clk(clk), .rst(rst), .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce),
        .per_img_data(din), .post_frame_vsync(o2_vs), .post_frame_href(o2_hr),
        .post_frame_clken(o2_ce), .post_img_data(o2_d));

    vip_color_space_convert #(.MODE(1)) u01 (
        .clk(clk), .rst(rst), .per_frame_vsync(o0_vs), .per_frame_href(o0_hr),
        .per_frame_clken(o0_ce), .per_img_data(o0_d), .post_frame_vsync(r_vs),
        .post_frame_href(r_hr), .post_frame_clken(r_ce), .post_img_data(r_d));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic close(input logic [7:0] a, input logic [7:0] b, input int tol);
        int diff;
        diff = int'(a) - int'(b);
        return (diff <= tol) && (diff >= -tol);
    endfunction

    // MODE0/MODE1 directed vectors, expected results worked from the equations
    logic [23:0] vin [5] = '{24'hFFFFFF, 24'h000000, 24'hFF0000, 24'hFF8080, 24'h008080};
    logic [23:0] e0  [5] = '{24'hFF8080, 24'h008080, 24'h4C55FF, 24'hA66ABF, 24'h599540};
    logic [23:0] e1  [5] = '{24'hFF78FF, 24'h008700, 24'h4BFF1C, 24'hFFFFFF, 24'h000000};

    // MODE2: odd 3-pixel line, blank, 2-pixel line
    logic [23:0] m2in  [10] = '{24'h0, 24'h005001, 24'h006002, 24'h007003, 24'h0,
                                24'h004010, 24'h00C020, 24'h0, 24'h0, 24'h0};
    logic        m2hr  [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [23:0] m2exp [10] = '{24'h0, 24'h015060, 24'h025060, 24'h037060, 24'h0,
                                24'h1040C0, 24'h2040C0, 24'h0, 24'h0, 24'h0};

    // Colour bar for the round trip, with per-colour tolerance
    logic [23:0] bar [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    int          tol [8] = '{2, 3, 3, 2, 3, 2, 2, 2};

    logic [2:0] hist [300];
    int         c0, c1, c2;
    logic       ok;

    initial begin
        rst = 1'b1; vs = 1'b0; hr = 1'b0; ce = 1'b0; din = '0;
        repeat (3) tick();
        chk("reset_d0", o0_d, 24'h0);
        chk("reset_d1", o1_d, 24'h0);
        chk("reset_d2", o2_d, 24'h0);
        chk("reset_sync", {15'h0, o0_vs, o0_hr, o0_ce, o1_vs, o1_hr, o1_ce, o2_vs, o2_hr, o2_ce},
            24'h0);
        rst = 1'b0;

        // Streamed matrix vectors, one per clock
        for (int i = 0; i < 7; i++) begin
            if (i < 5) begin
                din = vin[i]; hr = 1'b1; ce = 1'b1;
            end else begin
                din = '0; hr = 1'b0; ce = 1'b0;
            end
            tick();
            if (i >= 2) begin
                chk($sformatf("mode0_v%0d", i - 2), o0_d, e0[i - 2]);
                chk($sformatf("mode1_v%0d", i - 2), o1_d, e1[i - 2]);
            end
        end

        // 422 pairing, odd line tail, phase restart
        for (int i = 0; i < 10; i++) begin
            din = m2in[i]; hr = m2hr[i]; ce = m2hr[i];
            tick();
            if (i >= 2 && m2hr[i - 2]) begin
                chk($sformatf("mode2_p%0d", i - 2), o2_d, m2exp[i - 2]);
            end
        end

        // Random timing: outputs are inputs delayed 3 clocks
        for (int i = 0; i < 300; i++) begin
            vs = 1'($urandom_range(1)); hr = 1'($urandom_range(1)); ce = 1'($urandom_range(1));
            din = 24'($urandom);
            hist[i] = {vs, hr, ce};
            tick();
            if (i >= 2) begin
                chk("sync_m0", {21'h0, o0_vs, o0_hr, o0_ce}, {21'h0, hist[i - 2]});
                chk("sync_m1", {21'h0, o1_vs, o1_hr, o1_ce}, {21'h0, hist[i - 2]});
                chk("sync_m2", {21'h0, o2_vs, o2_hr, o2_ce}, {21'h0, hist[i - 2]});
            end
        end
        vs = 1'b0; hr = 1'b0; ce = 1'b0;
        repeat (5) tick();

        // Two 640-pixel lines: exactly 640 valid outputs per line
        for (int l = 0; l < 2; l++) begin
            c0 = 0; c1 = 0; c2 = 0;
            for (int p = 0; p < 660; p++) begin
                hr = (p < 640); ce = hr; din = 24'($urandom);
                tick();
                c0 += int'(o0_hr & o0_ce);
                c1 += int'(o1_hr & o1_ce);
                c2 += int'(o2_hr & o2_ce);
            end
            chk($sformatf("line%0d_cnt_m0", l), 24'(c0), 24'd640);
            chk($sformatf("line%0d_cnt_m1", l), 24'(c1), 24'd640);
            chk($sformatf("line%0d_cnt_m2", l), 24'(c2), 24'd640);
        end

        // Reset mid-line for 2 clocks
        hr = 1'b1; ce = 1'b1; din = 24'hFFFFFF;
        repeat (4) tick();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("midrst%0d_d0", k), o0_d, 24'h0);
            chk($sformatf("midrst%0d_d1", k), o1_d, 24'h0);
            chk($sformatf("midrst%0d_d2", k), o2_d, 24'h0);
            chk($sformatf("midrst%0d_sync", k),
                {18'h0, o0_hr, o0_ce, o1_hr, o1_ce, o2_hr, o2_ce}, 24'h0);
        end
        rst = 1'b0; din = 24'hFF0000;
        tick();
        din = 24'h000000;
        tick();
        tick();
        chk("postrst_m0", o0_d, 24'h4C55FF);
        chk("postrst_m1", o1_d, 24'h4BFF1C);
        chk("postrst_sync", {21'h0, o0_vs, o0_hr, o0_ce}, 24'h3);

        // Round trip MODE0 -> MODE1 over the colour bar
        for (int b = 0; b < 8; b++) begin
            din = bar[b];
            repeat (8) tick();
            ok = close(r_d[23:16], bar[b][23:16], tol[b]) &&
                 close(r_d[15:8],  bar[b][15:8],  tol[b]) &&
                 close(r_d[7:0],   bar[b][7:0],   tol[b]);
            chk($sformatf("roundtrip_%h_got_%h", bar[b], r_d), {23'h0, ok}, 24'h1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
